// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational RV32I ALU between
// NUM_REQ requesters. The winning request drives the ALU in the cycle it is
// accepted. The result lands in a single-entry response register that is
// returned with the requester ID under a valid/ready handshake.

package alu_share_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  alu_op_t            req_alu_op [NUM_REQ],
  input  word_t              req_in_a   [NUM_REQ],
  input  word_t              req_in_b   [NUM_REQ],
  output alu_op_t            alu_op,
  output word_t              alu_in_a,
  output word_t              alu_in_b,
  input  word_t              alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output word_t              rsp_result,
  output logic               rsp_zero
);

  // The response register is either holding a result or not.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            can_accept;
  logic            accept;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;

  assign rsp_valid  = (state_q == FULL);
  // A result can be taken whenever the slot is empty or is draining this cycle.
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = can_accept && grant_found;

  // Round-robin scan starting at rr_ptr; the first valid index wins.
  // grant_idx falls back to rr_ptr so the ALU inputs stay defined when idle.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves one unassigned infers a latch.
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // One-hot acceptance towards the winner, only when the response slot frees.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // The ALU always sees the winner, or requester rr_ptr when nobody is valid.
  always_comb begin
    alu_op   = req_alu_op[grant_idx];
    alu_in_a = req_in_a[grant_idx];
    alu_in_b = req_in_b[grant_idx];
  end

  // Priority pointer moves to the requester after the winner, wrapping to 0.
  always_comb begin
    next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Response slot occupancy: fill on accept, empty on drain without accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register for the response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the ALU outputs and requester ID on accept; hold them otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (accept) begin
      rr_ptr     <= next_ptr;
      rsp_id     <= grant_idx;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and a small
// behavioural ALU standing in for the external one.

module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  alu_op_t    req_alu_op [2];
  word_t      req_in_a   [2];
  word_t      req_in_b   [2];
  alu_op_t    alu_op;
  word_t      alu_in_a;
  word_t      alu_in_b;
  word_t      alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [0:0] rsp_id;
  word_t      rsp_result;
  logic       rsp_zero;

  int n_vec  = 0;
  int n_miss = 0;

  alu_share_arbiter #(.NUM_REQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_alu_op (req_alu_op),
    .req_in_a   (req_in_a),
    .req_in_b   (req_in_b),
    .alu_op     (alu_op),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU (only the ops the vectors use).
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = alu_in_a + alu_in_b;
      ALU_SUB: alu_result = alu_in_a - alu_in_b;
      ALU_AND: alu_result = alu_in_a & alu_in_b;
      ALU_OR:  alu_result = alu_in_a | alu_in_b;
      ALU_XOR: alu_result = alu_in_a ^ alu_in_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Per-requester operation lists, consumed in order as each one is accepted.
  alu_op_t r0_op [6] = '{ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
  word_t   r0_a  [6] = '{32'h5, 32'd10, 32'd20, 32'd30, 32'h40, 32'hFFFF_FFFF};
  word_t   r0_b  [6] = '{32'h3, 32'd1,  32'd2,  32'd3,  32'h2,  32'h1};
  alu_op_t r1_op [6] = '{ALU_SUB, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_OR};
  word_t   r1_a  [6] = '{32'hDEAD_BEEF, 32'd100, 32'd100, 32'h0000_FF00, 32'h1, 32'h1};
  word_t   r1_b  [6] = '{32'hDEAD_BEEF, 32'd1,   32'd100, 32'h0000_0FF0, 32'h2, 32'h2};
  int r0_i = 0;
  int r1_i = 0;

  // Expected results for the six-cycle round-robin burst.
  logic [0:0]  rr_id  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] rr_res [6] = '{32'd11, 32'h63, 32'd22, 32'h0, 32'd33, 32'h0F00};
  logic        rr_z   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present each requester's current operation with the given valid bits.
  task automatic drive(input logic [1:0] v);
    int i0;
    int i1;
    i0 = (r0_i > 5) ? 5 : r0_i;
    i1 = (r1_i > 5) ? 5 : r1_i;
    req_valid     = v;
    req_alu_op[0] = r0_op[i0];
    req_in_a[0]   = r0_a[i0];
    req_in_b[0]   = r0_b[i0];
    req_alu_op[1] = r1_op[i1];
    req_in_a[1]   = r1_a[i1];
    req_in_b[1]   = r1_b[i1];
  endtask

  // One cycle: drive at posedge+1, check req_ready mid-cycle, advance the
  // requester that handshook, and return at the next posedge+1.
  task automatic step(input string tag, input logic [1:0] v, input logic [1:0] exp_ready);
    drive(v);
    @(negedge clk);
    check(tag, 32'(req_ready), 32'(exp_ready));
    if (req_valid[0] && req_ready[0]) r0_i++;
    if (req_valid[1] && req_ready[1]) r1_i++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [0:0] id,
                           input logic [31:0] res, input logic z);
    check({tag, ".valid"},  32'(rsp_valid), 32'(v));
    check({tag, ".id"},     32'(rsp_id),    32'(id));
    check({tag, ".result"}, rsp_result,     res);
    check({tag, ".zero"},   32'(rsp_zero),  32'(z));
  endtask

  // Requester-side protocol: a waiting request keeps valid and payload stable.
  logic [1:0] pend = '0;
  alu_op_t    p_op [2];
  word_t      p_a  [2];
  word_t      p_b  [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && pend[i]) begin
        assert (req_valid[i] && req_alu_op[i] == p_op[i] &&
                req_in_a[i] == p_a[i] && req_in_b[i] == p_b[i])
          else $error("requester %0d dropped or changed a pending request", i);
      end
      pend[i] <= rst_n && req_valid[i] && !req_ready[i];
      p_op[i] <= req_alu_op[i];
      p_a[i]  <= req_in_a[i];
      p_b[i]  <= req_in_b[i];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(2'b11);
    #3;
    check_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First cycle after reset: requester 0 has priority; ADD 5+3.
    drive(2'b11);
    @(negedge clk);
    check("first.alu_in_a", alu_in_a, 32'h5);
    check("first.alu_op", 32'(alu_op), 32'(ALU_ADD));
    @(posedge clk);
    #1;
    // step() was bypassed for this cycle, so advance requester 0 by hand.
    r0_i++;
    check_rsp("add", 1'b1, 1'b0, 32'h8, 1'b0);

    // Requester 1 alone: SUB of equal operands gives zero.
    step("sub.ready", 2'b10, 2'b10);
    check_rsp("sub", 1'b1, 1'b1, 32'h0, 1'b1);

    // Both continuously valid with rsp_ready=1: strict alternation, no bubbles.
    for (int k = 0; k < 6; k++) begin
      step($sformatf("rr%0d.ready", k), 2'b11, rr_id[k] ? 2'b10 : 2'b01);
      check_rsp($sformatf("rr%0d", k), 1'b1, rr_id[k], rr_res[k], rr_z[k]);
    end

    // Backpressure: full slot with rsp_ready=0 blocks every requester.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stall%0d.ready", k), 2'b11, 2'b00);
      check_rsp($sformatf("stall%0d", k), 1'b1, 1'b1, 32'h0F00, 1'b0);
    end
    // Drain and accept in the same cycle: slot stays full with the new result.
    rsp_ready = 1'b1;
    step("drain_acc.ready", 2'b11, 2'b01);
    check_rsp("drain_acc", 1'b1, 1'b0, 32'h42, 1'b0);

    // Reset while full with requester 1 waiting.
    rsp_ready = 1'b0;
    drive(2'b10);
    @(negedge clk);
    check("wait.ready", 32'(req_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_rsp("async_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    // Pointer is back at 0, so requester 0 wins; 0xFFFFFFFF+1 wraps to zero.
    step("post_rst.ready", 2'b11, 2'b01);
    check_rsp("post_rst", 1'b1, 1'b0, 32'h0, 1'b1);
    step("req1_again.ready", 2'b10, 2'b10);
    check_rsp("req1_again", 1'b1, 1'b1, 32'h3, 1'b0);

    // Idle cycle: no grant, ALU driven from requester rr_ptr (=0); slot drains.
    drive(2'b00);
    @(negedge clk);
    check("idle.ready", 32'(req_ready), 32'h0);
    check("idle.alu_in_a", alu_in_a, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check_rsp("drain", 1'b0, 1'b1, 32'h3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational RV32I ALU instance between NUM_REQ requesters, e.g. the execute stage and an address/branch-target helper.
- Arbitration is round-robin, one operation per cycle, with a valid/ready handshake per requester.
- The chosen request drives the ALU. The ALU result is captured in a single-entry response register, returned with the requester ID under a valid/ready handshake.
- Sits between the requesters and the ALU; the ALU itself is instantiated outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (min 1), width of requester ID.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_alu_op  input  NUM_REQ x alu_op_t  per-requester operation.
- req_in_a  input  NUM_REQ x word_t  per-requester operand A.
- req_in_b  input  NUM_REQ x word_t  per-requester operand B.
- alu_op  output  alu_op_t  to ALU.
- alu_in_a  output  word_t(32)  to ALU.
- alu_in_b  output  word_t(32)  to ALU.
- alu_result  input  word_t(32)  from ALU, combinational.
- alu_zero  input  1  from ALU, combinational.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that produced the response.
- rsp_result  output  word_t(32)  captured ALU result.
- rsp_zero  output  1  captured ALU zero flag.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears all state: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rr_ptr=0 (requester 0 highest priority).
- Reset mid-operation discards any pending response. The in-flight requester sees no acceptance and must re-present its request.
- can_accept = !rsp_valid || rsp_ready. The block accepts one request per cycle at most, and only when can_accept=1.
- Grant: scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first index with req_valid=1 wins.
  - req_ready[g]=1 only when can_accept=1; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, rsp_valid, rsp_ready and rr_ptr.
- ALU drive:
  - With a grant, alu_op/alu_in_a/alu_in_b = the granted requester's fields, same cycle.
  - With no grant, they drive requester rr_ptr's fields, so the ALU inputs stay deterministic with no X.
- Acceptance (req_valid[g] && req_ready[g]) in cycle N, captured at the edge ending N:
  - rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_id <= g, rsp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle: rsp_valid is high in N+1.
- rr_ptr changes only on acceptance. An idle cycle or a stalled cycle leaves it unchanged.
- Response drain: rsp_valid && rsp_ready with no new acceptance gives rsp_valid <= 0. rsp_id/rsp_result/rsp_zero hold their last values.
- Simultaneous drain and accept: the response register is overwritten with the new result and rsp_valid stays 1, giving full throughput of 1 op/cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all req_ready=0. The response outputs must stay stable until accepted.
- Requester rule: once req_valid is raised, the requester holds valid and payload stable until req_ready. The bench checks this with an assertion.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 accepted operations.
- Reached-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on drain without accept.
  - FULL->FULL on stall, or on drain with accept.
- No arithmetic in this block beyond the mod-NUM_REQ pointer increment. The pointer wraps from NUM_REQ-1 to 0.

Test Plan:
- Reset with req_valid=2'b11 held -> req_ready[0]=1 first cycle (rr_ptr=0). After the edge: rsp_id=0, rsp_valid=1.
- Req0 ADD a=32'h0000_0005 b=32'h0000_0003, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=32'h8, rsp_zero=0, rsp_id=0.
- Req1 SUB a=b=32'hDEAD_BEEF -> rsp_result=0, rsp_zero=1, rsp_id=1, latency 1 cycle.
- Both requesters valid for 6 cycles, rsp_ready=1 -> grant sequence 0,1,0,1,0,1; 6 responses back-to-back, no bubbles.
- rsp_ready=0 for 3 cycles while FULL and both valid -> req_ready=0 throughout, rsp_* stable. When rsp_ready=1, the same-cycle accept/drain keeps rsp_valid=1 with the new rsp_id.
- Assert rst_n low while FULL with req1 waiting -> rsp_valid=0 immediately (async). After release, rr_ptr=0, so req0 wins if both are valid.
